// File: rtl/memory_access_controller_pkg.sv
// mem_ctrl_pkg: shared types and constants for the memory access controller.
//   state_e   - controller FSM encoding (IDLE / ACCESS / DONE)
//   grant_e   - which requester owns the current access (fetch / data)
//   ERR_RDATA - read data returned on an aborted (timed-out) access
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_e;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/memory_access_controller_if.sv
// memory_access_controller_if: bundles the fetch port, the data port, the
// status outputs and the unified memory port.
//   slave  - controller view: takes requests, returns acks, drives memory.
//   master - environment view: issues requests and models the memory.
interface memory_access_controller_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_ack;
    logic [DW-1:0] f_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic          err;
    logic          busy;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output f_ack, f_rdata, d_ack, d_rdata, err, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  f_ack, f_rdata, d_ack, d_rdata, err, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/memory_access_controller_arb.sv
// mem_rr_arbiter: combinational 2-way round-robin arbiter.
//   f_req, d_req - requests
//   last_grant   - owner of the previous completed access (held by parent)
//   grant        - winner; on a tie the port that did not go last wins
//   valid        - at least one request present
module mem_rr_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic   f_req,
    input  logic   d_req,
    input  grant_e last_grant,
    output grant_e grant,
    output logic   valid
);
    always_comb begin
        valid = f_req | d_req;
        grant = GNT_FETCH;
        if (f_req && d_req) begin
            grant = (last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
        end else if (d_req) begin
            grant = GNT_DATA;
        end
    end
endmodule

// File: rtl/memory_access_controller.sv
// memory_access_controller: shares one memory port between instruction fetch
// (read-only) and data load/store. Each access runs IDLE -> ACCESS -> DONE:
// request and operands are latched in IDLE, the memory is strobed in ACCESS
// until mem_ready, and the granted port gets a one-cycle ack in DONE.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-low reset
//   bus  - memory_access_controller_if.slave (requesters, status, memory)
// Optional feature: define MEM_TIMEOUT_EN to abort an ACCESS that has waited
// TIMEOUT_CYCLES cycles without mem_ready; the ack then carries err=1 and
// read data ERR_RDATA. Without it ACCESS waits indefinitely and err is 0.
module memory_access_controller
    import mem_ctrl_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    memory_access_controller_if.slave  bus
);
    state_e        state_q, state_d;
    grant_e        grant_q, grant_d;
    grant_e        last_grant_q, last_grant_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] data_q, data_d;
    logic          abort;

    grant_e arb_grant;
    logic   arb_valid;

    mem_rr_arbiter u_arb (
        .f_req      (bus.f_req),
        .d_req      (bus.d_req),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    assign abort = err_q;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= GNT_FETCH;
            last_grant_q <= GNT_DATA;   // fetch wins the first tie
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            data_q       <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    if (arb_grant == GNT_DATA) begin
                        addr_d  = bus.d_addr;
                        we_d    = bus.d_we;
                        wdata_d = bus.d_wdata;
                    end else begin
                        addr_d  = bus.f_addr;
                        we_d    = 1'b0;         // fetch is read-only
                        wdata_d = '0;
                    end
`ifdef MEM_TIMEOUT_EN
                    cnt_d = '0;
                    err_d = 1'b0;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.mem_ready) begin
                    if (!we_q) begin
                        data_d = bus.mem_rdata;
                    end
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                // A late mem_ready on the expiry cycle still completes normally.
                else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from registered state, so a reset edge clears
    // them for the following cycle.
    logic          in_access, in_done;
    logic [DW-1:0] ack_rdata;

    assign in_access = (state_q == ACCESS);
    assign in_done   = (state_q == DONE);
    assign ack_rdata = abort ? DW'(ERR_RDATA) : data_q;

    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_en    = in_access;
    assign bus.mem_we    = in_access & we_q;
    assign bus.mem_addr  = in_access ? addr_q  : '0;
    assign bus.mem_wdata = in_access ? wdata_q : '0;
    assign bus.f_ack     = in_done & (grant_q == GNT_FETCH);
    assign bus.d_ack     = in_done & (grant_q == GNT_DATA);
    assign bus.f_rdata   = bus.f_ack ? ack_rdata : '0;
    assign bus.d_rdata   = bus.d_ack ? ack_rdata : '0;
    assign bus.err       = in_done & abort;
endmodule

// File: tb/tb_memory_access_controller.sv
// Directed testbench for memory_access_controller: fetch-only read, waited
// data write, round-robin contention, ignored inputs, reset during ACCESS,
// and the timeout / no-timeout behaviour depending on MEM_TIMEOUT_EN.
module tb_memory_access_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic        model_en = 1'b0;
    logic [31:0] mem_rdata_drv = '0;

    always #5 clk = ~clk;

    memory_access_controller_if #(.AW(32), .DW(32)) bus ();

    memory_access_controller #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Simple memory model for contention: read data is the address XOR a key.
    assign bus.mem_rdata = model_en ? (bus.mem_addr ^ 32'hF0F0_0000) : mem_rdata_drv;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          n_acks;
        logic [3:0]  exp_data_grant;

        bus.f_req = 0; bus.f_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ready = 0;

        // Reset
        step(); step();
        check("rst_busy",   bus.busy, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_acks",   {bus.f_ack, bus.d_ack, bus.err}, 0);
        check("rst_rdata",  {bus.f_rdata, bus.d_rdata}, 0);
        rst = 1;
        step();

        // Fetch-only read, zero wait states
        bus.f_req = 1; bus.f_addr = 32'h100; bus.mem_ready = 1; mem_rdata_drv = 32'h1234_5678;
        check("f_c0_mem_en", bus.mem_en, 0);
        step();
        check("f_c1_mem_en", bus.mem_en, 1);
        check("f_c1_addr",   bus.mem_addr, 32'h100);
        check("f_c1_we",     bus.mem_we, 0);
        step();
        check("f_c2_ack",    {bus.f_ack, bus.d_ack, bus.err}, 3'b100);
        check("f_c2_rdata",  bus.f_rdata, 32'h1234_5678);
        bus.f_req = 0; bus.mem_ready = 0;
        step();
        check("f_c3_idle",   {bus.busy, bus.f_ack, bus.f_rdata}, 0);

        // Data write with two wait states
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hCAFE_F00D;
        mem_rdata_drv = 32'h5555_5555;
        for (int c = 1; c <= 3; c++) begin
            step();
            check($sformatf("w_c%0d_we", c), {bus.mem_en, bus.mem_we, bus.d_ack}, 3'b110);
            check($sformatf("w_c%0d_bus", c), {bus.mem_addr, bus.mem_wdata}, {32'h200, 32'hCAFE_F00D});
        end
        bus.mem_ready = 1;
        step();
        check("w_c4_ack",   {bus.d_ack, bus.f_ack, bus.err, bus.mem_en}, 4'b1000);
        check("w_c4_dreg",  bus.d_rdata, 32'h1234_5678);
        bus.d_req = 0; bus.d_we = 0; bus.mem_ready = 0;
        step();

        // Contention: both held, expect fetch, data, fetch, data
        bus.f_addr = 32'h300; bus.d_addr = 32'h400; model_en = 1; bus.mem_ready = 1;
        bus.f_req = 1; bus.d_req = 1;
        exp_data_grant = 4'b1010;
        n_acks = 0;
        for (int c = 0; c < 40 && n_acks < 4; c++) begin
            step();
            check("rr_no_overlap", bus.f_ack & bus.d_ack, 0);
            if (bus.f_ack || bus.d_ack) begin
                check($sformatf("rr_grant%0d", n_acks), bus.d_ack, exp_data_grant[n_acks]);
                check($sformatf("rr_rdata%0d", n_acks), bus.d_ack ? bus.d_rdata : bus.f_rdata,
                      exp_data_grant[n_acks] ? 32'hF0F0_0400 : 32'hF0F0_0300);
                n_acks++;
                if (n_acks == 4) begin
                    bus.f_req = 0; bus.d_req = 0;
                end
            end
        end
        check("rr_count", n_acks, 4);
        model_en = 0; bus.mem_ready = 0;
        step();

        // mem_ready in IDLE is ignored; operand changes after grant are ignored
        bus.mem_ready = 1;
        step(); step();
        check("ign_idle", {bus.busy, bus.mem_en, bus.f_ack, bus.d_ack}, 0);
        bus.mem_ready = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500;
        step();
        check("ign_c1_addr", bus.mem_addr, 32'h500);
        bus.d_addr = 32'h600;
        step();
        check("ign_c2_addr", bus.mem_addr, 32'h500);
        bus.mem_ready = 1; mem_rdata_drv = 32'h0BAD_CAFE;
        step();
        check("ign_ack",   {bus.d_ack, bus.err}, 2'b10);
        check("ign_rdata", bus.d_rdata, 32'h0BAD_CAFE);
        bus.d_req = 0; bus.mem_ready = 0;
        step();

        // Reset during ACCESS of a long read
        bus.d_req = 1; bus.d_addr = 32'h700;
        step();
        check("rm_c1_en", bus.mem_en, 1);
        step();
        rst = 0;
        step();
        check("rm_after", {bus.busy, bus.mem_en, bus.d_ack, bus.f_ack}, 0);
        rst = 1; bus.d_req = 0;
        step();
        check("rm_idle", {bus.busy, bus.d_ack}, 0);

        // Timeout behaviour
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h800; bus.mem_ready = 0;
`ifdef MEM_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("to_c%0d_wait", c), {bus.busy, bus.mem_en, bus.d_ack}, 3'b110);
        end
        step();
        check("to_ack",   {bus.d_ack, bus.err}, 2'b11);
        check("to_rdata", bus.d_rdata, 32'hDEAD_BEEF);
`else
        for (int c = 0; c < 20; c++) begin
            step();
        end
        check("nto_wait", {bus.busy, bus.mem_en, bus.d_ack}, 3'b110);
        bus.mem_ready = 1; mem_rdata_drv = 32'h0000_0077;
        step();
        check("nto_ack",   {bus.d_ack, bus.err}, 2'b10);
        check("nto_rdata", bus.d_rdata, 32'h0000_0077);
`endif
        bus.d_req = 0; bus.mem_ready = 0;
        step();
        check("end_idle", {bus.busy, bus.d_ack, bus.err}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_access_controller.md
Name: memory_access_controller

Overview:
- Sequences the single shared memory port between two requesters: instruction fetch (read-only) and data load/store (read/write).
- Arbitrates, latches address/write data into an internal address register, drives the memory handshake, captures read data into an internal data register, then acks the granted requester.
- Sits between the fetch and execute stages and the unified memory.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT_CYCLES, 16, max ACCESS cycles before abort (used only with MEM_TIMEOUT_EN); legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- f_req  in  1  fetch request; held until f_ack.
- f_addr  in  AW  fetch address.
- f_ack  out  1  one-cycle pulse when fetch completes.
- f_rdata  out  DW  fetch read data; valid while f_ack=1.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1=write, 0=read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_ack  out  1  one-cycle pulse when data access completes.
- d_rdata  out  DW  data read data; valid while d_ack=1 and d_we=0.
- err  out  1  access aborted; valid with f_ack/d_ack.
- busy  out  1  state != IDLE.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; sampled when mem_ready=1.
- mem_ready  in  1  memory completes access this cycle.

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE. All outputs 0. Internal address/data/wdata registers 0. last_grant=DATA, so fetch wins the first tie.
- States:
  - IDLE: if any req is high, arbitrate; latch addr, we (fetch forces 0) and wdata; record grant; go to ACCESS. Otherwise stay.
  - ACCESS: mem_en=1, mem_addr/mem_we/mem_wdata come from the latches. If mem_ready=1, capture mem_rdata into the data register (reads only; writes leave it unchanged) and go to DONE. If mem_ready=0, stay.
  - DONE: pulse ack of the granted port for exactly one cycle. That port's rdata = data register. Update last_grant. Go to IDLE.
- Arbitration:
  - One request only: grant it.
  - Both requests high: grant the port not in last_grant (round-robin).
- Latency:
  - req sampled in cycle 0 → mem_en in cycle 1 → ack in cycle 2 if mem_ready is high in cycle 1.
  - Each wait state adds one cycle. Maximum throughput is one access per 3 cycles.
- Requesters keep req/addr/wdata/we stable until ack. Changes after grant are ignored; the latched values are used.
- A req still high in the cycle after ack is treated as a new request.
- mem_en, mem_we, mem_addr, mem_wdata are 0 outside ACCESS.
- f_rdata/d_rdata are 0 when the corresponding ack is 0.
- mem_ready while not in ACCESS is ignored.
- Reset mid-ACCESS/DONE: return to IDLE at that edge, no ack issued, mem_en=0 from the next cycle.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES-1 with mem_ready still 0, go to DONE with err=1 and rdata forced to ERR_RDATA (32'hDEAD_BEEF).
  - The data register is not updated. mem_ready in the same cycle as expiry takes precedence (normal completion, err=0).
- Undefined: no counter; ACCESS waits indefinitely; err tied to 0.

Decomposition:
- Package mem_ctrl_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), grant constants (GNT_FETCH=1'b0, GNT_DATA=1'b1), ERR_RDATA.
- Sub-module mem_rr_arbiter: 2-way round-robin arbiter (inputs f_req, d_req, last_grant; outputs grant, valid). Combinational only; last_grant is held in the parent.

Test Plan:
- Fetch-only: f_req=1, f_addr=0x100, mem_ready=1 in cycle 1, mem_rdata=0x12345678 → mem_en=1/mem_addr=0x100 in cycle 1; f_ack=1, f_rdata=0x12345678 in cycle 2; d_ack=0.
- Data write with 2 wait states: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xCAFEF00D → mem_we=1 for 3 cycles; d_ack in cycle 4; data register unchanged.
- Contention: f_req and d_req held high for 4 accesses → grants in order fetch, data, fetch, data; no overlapping acks.
- Reset mid-ACCESS: rst=0 in cycle 2 of a 5-wait-state read → busy=0 and mem_en=0 next cycle; no ack pulse.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): d_req read, mem_ready=0 → d_ack with err=1 and d_rdata=0xDEADBEEF after 4 ACCESS cycles. Without the macro, busy stays 1 until mem_ready is asserted.
- Ignored inputs: mem_ready=1 in IDLE → no state change. d_addr changed after grant → mem_addr keeps the latched value.
